uart_tx_arbiter: RTL and testbench

//   Shares one UartTxEn transmitter among NREQ byte-stream requesters (e.g. core console, debug, DMA log).

---
 rtl/uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-atomic arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_PKT      = 16,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_done,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Terminal values of the two bounded counters; comparing against these
  // means neither counter can ever wrap.
  localparam logic [7:0]  PKT_LAST  = 8'(MAX_PKT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_START,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic              last_q, last_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW-1:0]   cand;
  int                cand_i;

  logic              owner_valid;
  logic [7:0]        owner_data;
  logic              owner_last;
  logic [IDXW-1:0]   owner_next;
  logic              release_own;

  // Round-robin search: first valid requester starting at rr_ptr and wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    cand_i     = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_i = int'(rr_ptr_q) + k;
      if (cand_i >= NREQ) begin
        cand_i = cand_i - NREQ;
      end
      cand = IDXW'(cand_i);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Route the current owner's valid/data/last onto single-lane signals.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    owner_last  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == IDXW'(k)) begin
        owner_valid = req_valid[k];
        owner_data  = req_data[8*k +: 8];
        owner_last  = req_last[k];
      end
    end
  end

  // Pointer value after release: the requester just behind the owner.
  always_comb begin
    if (owner_q == IDXW'(NREQ - 1)) begin
      owner_next = '0;
    end else begin
      owner_next = owner_q + IDXW'(1);
    end
  end

  // Only the owner can see ready, and only while waiting for its next byte.
  always_comb begin
    if (state_q == S_XFER) begin
      req_ready = grant_q & req_valid;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and datapath updates for the grant/transfer sequence.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    release_own = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          hold_cnt_d = '0;
          state_d    = S_XFER;
          for (int k = 0; k < NREQ; k++) begin
            grant_d[k] = (pick_idx == IDXW'(k));
          end
        end
      end

      S_XFER: begin
        if (owner_valid) begin
          tx_data_d  = owner_data;
          last_d     = owner_last;
          tx_valid_d = 1'b1;
          state_d    = S_START;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Owner stalled too long between bytes; let others in.
          release_own = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (tx_done) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (last_q || (byte_cnt_q == PKT_LAST)) begin
            release_own = 1'b1;
          end else begin
            hold_cnt_d = '0;
            state_d    = S_XFER;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Release always passes through IDLE so there is a gap between grants.
    if (release_own) begin
      grant_d  = '0;
      rr_ptr_d = owner_next;
      state_d  = S_IDLE;
    end
  end

  // State register; reset abandons any in-flight byte immediately.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        nReset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_done;
  logic [3:0]  grant;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] src_data [4][24];
  logic       src_last [4][24];
  int         src_len  [4];
  int         src_pos  [4];

  logic [7:0] log_data  [32];
  logic [3:0] log_grant [32];
  int         log_cyc   [32];
  int         log_n;
  logic [3:0] gtrace    [1024];
  int         first_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ         (4),
    .MAX_PKT      (16),
    .HOLD_TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_done   (tx_done),
    .grant     (grant),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nReset    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    step();
    step();
    nReset = 1'b1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      log_data[i]  = 'x;
      log_grant[i] = 'x;
      log_cyc[i]   = -1;
    end
    log_n      = 0;
    first_done = -1;
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_len[r]] = d;
    src_last[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  task automatic expect_log(input string tag, input int idx, input logic [7:0] d, input logic [3:0] g);
    check(tag, {20'h0, log_grant[idx], log_data[idx]}, {20'h0, g, d});
  endtask

  // Requesters feed their queued bytes; the UART answers tx_done dly cycles after each tx_valid.
  task automatic run(input int dly, input int budget, input string tag);
    int         done_cnt;
    logic [3:0] rdy;
    logic [3:0] prev_g;
    logic       prev_v;
    logic [7:0] held;
    bit         perr;
    bit         finished;
    bit         all_done;
    done_cnt = -1;
    prev_g   = '0;
    prev_v   = 1'b0;
    held     = '0;
    perr     = 1'b0;
    finished = 1'b0;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (src_pos[i] < src_len[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_data[i][src_pos[i]];
          req_last[i]        = src_last[i][src_pos[i]];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = '0;
          req_last[i]        = 1'b0;
        end
      end
      tx_done = (done_cnt == 0);
      if (done_cnt == 0 && first_done < 0) first_done = cyc;
      #1;
      rdy = req_ready;
      if (cyc < 1024) gtrace[cyc] = grant;
      if (!$onehot0(grant) || !$onehot0(rdy) || ((rdy & ~(grant & req_valid)) != 4'h0)) perr = 1'b1;
      if (prev_g != 4'h0 && grant != 4'h0 && grant != prev_g) perr = 1'b1;
      if (tx_valid) begin
        if (prev_v) perr = 1'b1;
        if (log_n < 32) begin
          log_data[log_n]  = tx_data;
          log_grant[log_n] = grant;
          log_cyc[log_n]   = cyc;
          log_n++;
        end
        held     = tx_data;
        done_cnt = dly;
      end else if (done_cnt >= 0 && tx_data !== held) begin
        perr = 1'b1;
      end
      prev_v = tx_valid;
      prev_g = grant;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) src_pos[i]++;
      end
      if (done_cnt >= 0) done_cnt--;
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (src_pos[i] < src_len[i]) all_done = 1'b0;
      end
      finished = all_done && !busy && (done_cnt < 0);
    end
    tx_done   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    check({tag, "_finished"}, {31'h0, finished}, 32'h1);
    check({tag, "_protocol"}, {31'h0, perr}, 32'h0);
  endtask

  initial begin
    nReset    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    step();
    step();
    check("rst_grant",     grant,          0);
    check("rst_req_ready", req_ready,      0);
    check("rst_tx_valid",  tx_valid,       0);
    check("rst_tx_data",   tx_data,        0);
    check("rst_busy",      busy,           0);
    check("rst_rr_ptr",    dut.rr_ptr_q,   0);
    nReset = 1'b1;

    // 1: req0 sends 41,42,43(last), done 20 cycles after each tx_valid
    clear_src();
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b0);
    add_byte(0, 8'h43, 1'b1);
    run(20, 200, "t1");
    check("t1_count", log_n, 3);
    expect_log("t1_b0", 0, 8'h41, 4'b0001);
    expect_log("t1_b1", 1, 8'h42, 4'b0001);
    expect_log("t1_b2", 2, 8'h43, 4'b0001);
    check("t1_first_tx_valid_cycle", log_cyc[0], 2);
    check("t1_second_tx_valid_cycle", log_cyc[1], 24);
    check("t1_third_tx_valid_cycle", log_cyc[2], 46);
    check("t1_first_done_cycle", first_done, 22);
    check("t1_grant_after", grant, 0);
    check("t1_rr_ptr_after", dut.rr_ptr_q, 1);

    // 2b: rr_ptr=1, req0 and req2 together -> req2 first
    clear_src();
    add_byte(0, 8'hA0, 1'b0);
    add_byte(0, 8'hA1, 1'b1);
    add_byte(2, 8'hC0, 1'b0);
    add_byte(2, 8'hC1, 1'b1);
    run(4, 200, "t2b");
    check("t2b_count", log_n, 4);
    expect_log("t2b_b0", 0, 8'hC0, 4'b0100);
    expect_log("t2b_b1", 1, 8'hC1, 4'b0100);
    expect_log("t2b_b2", 2, 8'hA0, 4'b0001);
    expect_log("t2b_b3", 3, 8'hA1, 4'b0001);

    // 2a: after reset rr_ptr=0 -> req0 packet then req2 packet
    do_reset();
    clear_src();
    add_byte(0, 8'hA0, 1'b0);
    add_byte(0, 8'hA1, 1'b1);
    add_byte(2, 8'hC0, 1'b0);
    add_byte(2, 8'hC1, 1'b1);
    run(4, 200, "t2a");
    check("t2a_count", log_n, 4);
    expect_log("t2a_b0", 0, 8'hA0, 4'b0001);
    expect_log("t2a_b1", 1, 8'hA1, 4'b0001);
    expect_log("t2a_b2", 2, 8'hC0, 4'b0100);
    expect_log("t2a_b3", 3, 8'hC1, 4'b0100);
    check("t2a_rr_ptr_after", dut.rr_ptr_q, 3);

    // 3: req1 20-byte packet with req3 waiting, forced release after 16 bytes
    do_reset();
    clear_src();
    for (int i = 0; i < 20; i++) add_byte(1, 8'(8'h60 + i), (i == 19));
    add_byte(3, 8'hD0, 1'b0);
    add_byte(3, 8'hD1, 1'b1);
    run(4, 400, "t3");
    check("t3_count", log_n, 22);
    for (int i = 0; i < 16; i++) expect_log("t3_req1_first", i, 8'(8'h60 + i), 4'b0010);
    expect_log("t3_req3_b0", 16, 8'hD0, 4'b1000);
    expect_log("t3_req3_b1", 17, 8'hD1, 4'b1000);
    for (int i = 0; i < 4; i++) expect_log("t3_req1_rest", 18 + i, 8'(8'h70 + i), 4'b0010);

    // 4: req0 stalls after one non-last byte -> release 64 cycles after re-entering XFER
    do_reset();
    clear_src();
    add_byte(0, 8'h55, 1'b0);
    add_byte(1, 8'h99, 1'b1);
    run(4, 300, "t4");
    check("t4_count", log_n, 2);
    expect_log("t4_b0", 0, 8'h55, 4'b0001);
    expect_log("t4_b1", 1, 8'h99, 4'b0010);
    check("t4_done_cycle", first_done, 6);
    check("t4_grant_last_hold_cycle", gtrace[6 + 64], 4'b0001);
    check("t4_grant_released", gtrace[6 + 65], 4'b0000);
    check("t4_grant_req1", gtrace[6 + 66], 4'b0010);

    // 5: stray tx_done in IDLE and in XFER
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t5_idle_busy", busy, 0);
    check("t5_idle_grant", grant, 0);
    check("t5_idle_tx_valid", tx_valid, 0);
    req_valid = 4'b0001;
    req_data  = 32'h77;
    req_last  = 4'b0000;
    step();
    req_valid = 4'b0000;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    check("t5_xfer_grant", grant, 4'b0001);
    check("t5_xfer_busy", busy, 1);
    check("t5_xfer_tx_valid", tx_valid, 0);
    check("t5_xfer_byte_cnt", dut.byte_cnt_q, 0);
    repeat (70) step();
    check("t5_timeout_grant", grant, 0);
    check("t5_timeout_busy", busy, 0);

    // 6: reset while waiting for byte 2 to finish
    req_valid = 4'b0001;
    req_data  = 32'h31;
    req_last  = 4'b0000;
    step();
    check("t6_ready_b1", req_ready, 4'b0001);
    step();
    check("t6_tx_valid_b1", tx_valid, 1);
    check("t6_tx_data_b1", tx_data, 8'h31);
    req_data = 32'h32;
    step();
    check("t6_tx_valid_pulse", tx_valid, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    req_data = 32'h33;
    step();
    check("t6_wait_tx_data", tx_data, 8'h32);
    check("t6_wait_busy", busy, 1);
    check("t6_wait_grant", grant, 4'b0001);
    nReset    = 1'b0;
    req_valid = 4'b0101;
    req_data  = '0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_tx_data", tx_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rr_ptr", dut.rr_ptr_q, 0);
    step();
    nReset = 1'b1;
    step();
    check("t6_fresh_grant", grant, 4'b0001);
    req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
